// File: rtl/maze_mem_pkg.sv
// Shared types and constants for the maze cell-memory arbiter.
// Holds the FSM state enum, requester ids and default geometry.
package maze_mem_pkg;

  localparam int N_DEF    = 2;
  localparam int SIZE_DEF = 256;
  localparam int AW_DEF   = 16;

  localparam logic [1:0] LOADER  = 2'd0;
  localparam logic [1:0] SOLVER  = 2'd1;
  localparam logic [1:0] DISPLAY = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  function automatic logic [2:0] id2onehot(input logic [1:0] id);
    logic [2:0] v;
    case (id)
      LOADER:  v = 3'b001;
      SOLVER:  v = 3'b010;
      DISPLAY: v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin selector: the search starts one past the last winner.
// Purely combinational; the caller registers the winner.
module rr_arbiter3
  import maze_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       any
);

  // Priority order rotates with the previous winner
  always_comb begin
    win = LOADER;
    any = |req;
    case (last)
      LOADER: begin
        if (req[1])      win = SOLVER;
        else if (req[2]) win = DISPLAY;
        else             win = LOADER;
      end
      SOLVER: begin
        if (req[2])      win = DISPLAY;
        else if (req[0]) win = LOADER;
        else             win = SOLVER;
      end
      default: begin
        if (req[0])      win = LOADER;
        else if (req[1]) win = SOLVER;
        else             win = DISPLAY;
      end
    endcase
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbitrates loader/solver/display access to the maze cell memory and runs
// full-memory clear sweeps. Outputs are decoded from state and latched fields.
module maze_mem_arbiter
  import maze_mem_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SIZE = SIZE_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          busy,
  input  logic [2:0]    req,
  input  logic [2:0]    we,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [AW-1:0] adr2,
  input  logic [N-1:0]  wdata0,
  input  logic [N-1:0]  wdata1,
  input  logic [N-1:0]  wdata2,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [N-1:0]  rdata,
  output logic          err,
  output logic [AW-1:0] mem_adr,
  output logic [N-1:0]  mem_din,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [N-1:0]  mem_dout
);

  // One spare bit so the sweep counter can never wrap before it terminates
  localparam int              CW       = $clog2(SIZE) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(SIZE - 1);
  localparam logic [AW:0]     SIZE_W   = (AW + 1)'(SIZE);

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_last;
  logic [1:0]    r_id;
  logic          r_we;
  logic          r_oor;
  logic [AW-1:0] r_adr;
  logic [N-1:0]  r_wdata;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_win;
  logic          w_any;
  logic [AW-1:0] w_sel_adr;
  logic [N-1:0]  w_sel_wdata;
  logic          w_sel_we;
  logic          w_accept;

  rr_arbiter3 u_rr (
    .req  (req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  // Route the winning requester's fields to the capture registers
  always_comb begin
    w_sel_adr   = adr2;
    w_sel_wdata = wdata2;
    w_sel_we    = we[2];
    case (w_win)
      LOADER: begin
        w_sel_adr   = adr0;
        w_sel_wdata = wdata0;
        w_sel_we    = we[0];
      end
      SOLVER: begin
        w_sel_adr   = adr1;
        w_sel_wdata = wdata1;
        w_sel_we    = we[1];
      end
      default: begin
        w_sel_adr   = adr2;
        w_sel_wdata = wdata2;
        w_sel_we    = we[2];
      end
    endcase
  end

  assign w_accept = (r_state == IDLE) && !clr_start && w_any;

  // Next-state logic; clear has priority over pending requests
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (clr_start)  w_next = CLEAR;
        else if (w_any) w_next = ISSUE;
        else            w_next = IDLE;
      end
      ISSUE: begin
        if (r_we) w_next = IDLE;
        else      w_next = WAIT_RD;
      end
      WAIT_RD: w_next = IDLE;
      CLEAR: begin
        if (r_cnt == LAST_CNT) w_next = IDLE;
        else                   w_next = CLEAR;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, round-robin history, captured request and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= DISPLAY;
      r_id    <= LOADER;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last  <= w_win;
        r_id    <= w_win;
        r_we    <= w_sel_we;
        r_oor   <= ({1'b0, w_sel_adr} >= SIZE_W);
        r_adr   <= w_sel_adr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == CLEAR) begin
        if (r_cnt == LAST_CNT) r_cnt <= '0;
        else                   r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Output decode: depends only on state and registered fields (mem_dout aside)
  always_comb begin
    gnt       = 3'b000;
    rvalid    = 3'b000;
    rdata     = '0;
    err       = 1'b0;
    busy      = 1'b0;
    mem_adr   = '0;
    mem_din   = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    case (r_state)
      ISSUE: begin
        gnt       = id2onehot(r_id);
        err       = r_oor;
        mem_adr   = r_adr;
        mem_din   = r_wdata;
        mem_write = r_we && !r_oor;
        mem_read  = !r_we && !r_oor;
      end
      WAIT_RD: begin
        rvalid = id2onehot(r_id);
        if (r_oor) rdata = '0;
        else       rdata = mem_dout;
      end
      CLEAR: begin
        busy      = 1'b1;
        mem_adr   = AW'(r_cnt);
        mem_write = 1'b1;
      end
      default: begin
        gnt = 3'b000;
      end
    endcase
  end

endmodule

// File: doc/maze_mem_arbiter.md
MAZE_MEM_ARBITER -- requirements
Module: maze_mem_arbiter

Interface
REQ-001 The block SHALL take parameter N, default 2, as the maze-cell data width.
REQ-002 The block SHALL take parameter SIZE, default 256, as the cell count (16x16 maze).
REQ-003 The block SHALL take parameter AW, default 16, as the address width.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 clr_start  input  1  pulse: start a full-memory clear sweep.
REQ-007 busy  output  1  high while a clear sweep runs.
REQ-008 req[2:0]  input  3  per-requester request (0 loader, 1 solver, 2 display).
REQ-009 we[2:0]  input  3  per-requester write enable; 1 = write, 0 = read.
REQ-010 adr0/adr1/adr2  input  AW  per-requester cell address.
REQ-011 wdata0/wdata1/wdata2  input  N  per-requester write data.
REQ-012 gnt[2:0]  output  3  one-cycle grant pulse; the request is accepted.
REQ-013 rvalid[2:0]  output  3  one-cycle read-data-valid pulse.
REQ-014 rdata  output  N  read data; qualified by rvalid.
REQ-015 err  output  1  pulses with gnt when the address is >= SIZE.
REQ-016 mem_adr  output  AW  address to the cell memory.
REQ-017 mem_din  output  N  write data to the cell memory.
REQ-018 mem_write, mem_read  output  1 each  memory strobes; never both high.
REQ-019 mem_dout  input  N  registered memory read data; valid one cycle after mem_read.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT_RD and CLEAR.
REQ-021 IDLE: if clr_start is high, go to CLEAR; otherwise, if any req bit is set, latch the winner's id, we, address and data, then go to ISSUE.
REQ-022 Arbitration SHALL be round-robin: search starts at (last winner + 1) mod 3; the last winner after reset is 2.
REQ-023 ISSUE SHALL pulse gnt[winner] for exactly one cycle and drive mem_adr and mem_din from the latched values.
REQ-024 ISSUE, write, in range: mem_write=1 for one cycle, then go to IDLE.
REQ-025 ISSUE, read, in range: mem_read=1 for one cycle, then go to WAIT_RD.
REQ-026 WAIT_RD: rdata=mem_dout and rvalid[winner]=1 for one cycle, then go to IDLE.
REQ-027 Read latency SHALL be 3 cycles from IDLE acceptance to rvalid; write occupancy SHALL be 2 cycles.
REQ-028 An address >= SIZE SHALL assert err with gnt and issue no strobe; a read SHALL still return rvalid with rdata=0 in WAIT_RD.
REQ-029 Requesters SHALL hold req, we, adr and wdata stable until gnt; a req still high after gnt is a new request.
REQ-030 CLEAR: busy=1; write 0 to addresses 0..SIZE-1, one per cycle, with mem_write=1, then go to IDLE. busy drops in the cycle after the write to SIZE-1.
REQ-031 clr_start outside IDLE SHALL be ignored, and req SHALL NOT be granted during CLEAR.
REQ-032 clr_start and req high together in IDLE: CLEAR SHALL win, and the requests SHALL stay pending.
REQ-033 The clear counter SHALL be log2(SIZE)+1 bits wide to avoid wrap before termination.
REQ-034 All outputs SHALL be registered or decoded from state only; there is no combinational path from req to mem_*.

Reset
REQ-035 rst SHALL force IDLE, last winner = 2, and the clear counter to 0 immediately.
REQ-036 At reset, gnt, rvalid, err, busy, mem_write and mem_read SHALL be 0, and mem_adr, mem_din and rdata SHALL be 0.
REQ-037 Reset mid-access or mid-clear SHALL abort it with no gnt or rvalid afterwards; memory contents are not restored.

Structure
REQ-038 Package maze_mem_pkg SHALL hold the state enum, the requester id constants (LOADER=0, SOLVER=1, DISPLAY=2), and the defaults for N, SIZE and AW.
REQ-039 Round-robin selection SHALL be a sub-module rr_arbiter3 with inputs req[2:0] and last[1:0], and outputs win[1:0] and any.

Verification
REQ-040 clr_start pulse after reset -> busy high for 256 cycles; 256 writes of 0 at addresses 0..255 in order; busy low afterwards.
REQ-041 req=3'b111: loader write adr0=5, wdata0=2'b11; solver read adr1=5; display read adr2=7 -> grants in order 0, 1, 2; solver rdata=2'b11 three cycles after its acceptance.
REQ-042 Solver read adr1=300 -> gnt[1] and err together, no mem strobe, rvalid[1] with rdata=0.
REQ-043 clr_start and req[2] high together in IDLE -> clear runs first; gnt[2] follows the clear.
REQ-044 rst asserted in WAIT_RD -> no rvalid; all outputs 0; the next req[0] after reset is granted first.
